// File: rtl/seg_scan_if.sv
// Bus bundle between a display data source and the seg_scan controller.
// The source (master) drives data and control; the controller (slave) drives the scan outputs.
interface seg_scan_if;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        load;
    logic [7:0]  digit_en;
    logic [2:0]  num;
    logic [7:0]  seg;
    logic        blank;
    logic        frame;
    logic        pending;

    modport master (
        output data, dp, load, digit_en,
        input  num, seg, blank, frame, pending
    );

    modport slave (
        input  data, dp, load, digit_en,
        output num, seg, blank, frame, pending
    );
endinterface

// File: rtl/seg_scan.sv
// Eight-digit seven-segment scan controller with frame-aligned double-buffered data.
// num/seg/blank/frame are all registered from the same next-state values, so they never skew.
module seg_scan #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int            CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    num_reg, num_next;
    logic [31:0]   disp_data_reg, disp_data_next;
    logic [7:0]    disp_dp_reg, disp_dp_next;
    logic [31:0]   sh_data_reg, sh_data_next;
    logic [7:0]    sh_dp_reg, sh_dp_next;
    logic          pending_reg, pending_next;
    logic [7:0]    seg_reg, seg_next;
    logic          blank_reg, blank_next;
    logic          frame_reg, frame_next;
    logic          slot_end;
    logic          boundary;
    logic [7:0]    glyph_all [8];

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Patterns are built from the display contents that will hold after this edge.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign glyph_all[gi] = {~disp_dp_next[gi], hex_glyph(disp_data_next[4*gi +: 4])};
    end

    always_comb begin
        slot_end       = (cnt_reg == CNT_MAX);
        boundary       = slot_end && (num_reg == 3'd7);
        cnt_next       = slot_end ? '0 : cnt_reg + 1'b1;
        num_next       = slot_end ? num_reg + 3'd1 : num_reg;
        disp_data_next = disp_data_reg;
        disp_dp_next   = disp_dp_reg;
        sh_data_next   = sh_data_reg;
        sh_dp_next     = sh_dp_reg;
        pending_next   = pending_reg;

        if (bus.load) begin
            sh_data_next = bus.data;
            sh_dp_next   = bus.dp;
            pending_next = 1'b1;
        end

        // A load landing on the boundary bypasses the shadow and goes straight to display.
        if (boundary) begin
            pending_next = 1'b0;
            if (bus.load) begin
                disp_data_next = bus.data;
                disp_dp_next   = bus.dp;
            end else if (pending_reg) begin
                disp_data_next = sh_data_reg;
                disp_dp_next   = sh_dp_reg;
            end
        end

        blank_next = (cnt_next < BLANK_C) || !bus.digit_en[num_next];
        seg_next   = blank_next ? 8'hFF : glyph_all[num_next];
        frame_next = (cnt_next == '0) && (num_next == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            num_reg       <= '0;
            disp_data_reg <= '0;
            disp_dp_reg   <= '0;
            sh_data_reg   <= '0;
            sh_dp_reg     <= '0;
            pending_reg   <= 1'b0;
            seg_reg       <= 8'hFF;
            blank_reg     <= 1'b1;
            frame_reg     <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            num_reg       <= num_next;
            disp_data_reg <= disp_data_next;
            disp_dp_reg   <= disp_dp_next;
            sh_data_reg   <= sh_data_next;
            sh_dp_reg     <= sh_dp_next;
            pending_reg   <= pending_next;
            seg_reg       <= seg_next;
            blank_reg     <= blank_next;
            frame_reg     <= frame_next;
        end
    end

    assign bus.num     = num_reg;
    assign bus.seg     = seg_reg;
    assign bus.blank   = blank_reg;
    assign bus.frame   = frame_reg;
    assign bus.pending = pending_reg;
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at DIV=8, BLANK=2: scan timing, loads, blanking, dp and reset.
// Every cycle is compared against a small frame model; key points also get hand-computed constants.
module tb_seg_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_if bus ();

    seg_scan #(.DIV(8), .BLANK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          t            = 0;
    logic [31:0] disp_e = '0, sh_e = '0;
    logic [7:0]  dpd_e  = '0, shdp_e = '0, en_e = 8'hFF;
    logic        pend_e = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    // Compare the current cycle against the model, then advance one clock.
    task automatic tick();
        int         c, n;
        logic [3:0] nib;
        logic [7:0] g, seg_e;
        logic       blank_e;
        c       = t % 8;
        n       = (t / 8) % 8;
        nib     = disp_e[4*n +: 4];
        g       = GLYPH[nib];
        blank_e = (c < 2) || !en_e[n];
        seg_e   = blank_e ? 8'hFF : {~dpd_e[n], g[6:0]};
        check("num", bus.num, n);
        check("seg", bus.seg, seg_e);
        check("blank", bus.blank, blank_e);
        check("frame", bus.frame, (t % 64 == 0) && (t != 0));
        check("pending", bus.pending, pend_e);

        if (t % 64 == 63) begin
            if (bus.load) begin
                disp_e = bus.data;
                dpd_e  = bus.dp;
                sh_e   = bus.data;
                shdp_e = bus.dp;
            end else if (pend_e) begin
                disp_e = sh_e;
                dpd_e  = shdp_e;
            end
            pend_e = 1'b0;
        end else if (bus.load) begin
            sh_e   = bus.data;
            shdp_e = bus.dp;
            pend_e = 1'b1;
        end
        en_e = bus.digit_en;

        @(posedge clk);
        #1;
        t++;
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p);
        bus.data = d;
        bus.dp   = p;
        bus.load = 1'b1;
        $display("[TB] load data=%h dp=%h at t=%0d", d, p, t);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_num"}, bus.num, 0);
        check({tag, "_seg"}, bus.seg, 8'hFF);
        check({tag, "_blank"}, bus.blank, 1);
        check({tag, "_frame"}, bus.frame, 0);
        check({tag, "_pending"}, bus.pending, 0);
    endtask

    initial begin
        bus.data     = '0;
        bus.dp       = '0;
        bus.load     = 1'b0;
        bus.digit_en = 8'hFF;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;

        run_to(20);
        do_load(32'h76543210, 8'h00);
        check("pend_set", bus.pending, 1);
        run_to(127);
        bus.digit_en = 8'b1111_1011;
        tick();
        run_to(148);
        check("en_off_seg", bus.seg, 8'hFF);
        check("en_off_blank", bus.blank, 1);
        run_to(191);
        bus.digit_en = 8'hFF;
        tick();

        run_to(200);
        do_load(32'hFEDCBA98, 8'h81);
        run_to(258);
        check("dp_d0", bus.seg, 8'h00);
        run_to(266);
        check("hex_d1", bus.seg, 8'h90);
        run_to(282);
        do_load(32'h11111111, 8'h00);
        run_to(297);
        do_load(32'h22222222, 8'h02);
        run_to(314);
        check("dp_d7", bus.seg, 8'h0E);
        run_to(330);
        check("last_load_d1", bus.seg, 8'h24);

        run_to(383);
        do_load(32'hCAFEBABE, 8'h10);
        check("bnd_pend", bus.pending, 0);
        run_to(386);
        check("bnd_d0", bus.seg, 8'h86);
        run_to(418);
        check("bnd_d4", bus.seg, 8'h06);
        run_to(419);
        do_load(32'h33333333, 8'hFF);
        run_to(421);

        // Mid-frame reset with a simultaneous load that must be ignored.
        rst      = 1'b1;
        bus.load = 1'b1;
        bus.data = 32'h44444444;
        bus.dp   = 8'hFF;
        $display("[TB] reset at t=%0d with load held", t);
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        rst      = 1'b0;
        bus.load = 1'b0;
        t        = 0;
        disp_e   = '0;
        dpd_e    = '0;
        sh_e     = '0;
        shdp_e   = '0;
        pend_e   = 1'b0;
        run_to(66);
        check("rst_cleared_d0", bus.seg, 8'hC0);
        run_to(140);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds a 32-bit hex value, steps a digit index 0→7 at a programmable rate and drives that index on `num` to the 3-to-8 anode decoder. In the same cycle it drives the active-low segment pattern for the selected digit on `seg`. New data is double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new data.

## Interface
- `DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- `BLANK`, 1000: cycles at the start of each slot with all segments off (anti-ghosting); legal range 0 ≤ BLANK < DIV; 0 disables blanking.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  32  hex value; digit i displays `data[4i+3:4i]`.
- `dp`  in  8  decimal-point request; bit i lights the point of digit i.
- `load`  in  1  one-cycle strobe; captures `data` and `dp` into the shadow register.
- `digit_en`  in  8  live per-digit enable; not latched.
- `num`  out  3  current digit index, to the anode decoder.
- `seg`  out  8  active-low segments; bit0=a … bit6=g, bit7=dp.
- `blank`  out  1  high whenever `seg` is forced to 8'hFF.
- `frame`  out  1  one-cycle pulse at the start of each frame.
- `pending`  out  1  shadow data is waiting for the next frame boundary.

## Operation
- State:
  - slot counter `cnt`, 0..DIV-1, width $clog2(DIV);
  - digit index `num`;
  - display registers `disp_data[31:0]`, `disp_dp[7:0]`;
  - shadow registers `sh_data`, `sh_dp`;
  - `pending` flag.
- Counting:
  - `cnt` increments every cycle and wraps DIV-1→0.
  - On that wrap, `num` increments modulo 8 (7→0).
- Boundary cycle: `num==7 && cnt==DIV-1`.
  - On its edge, `disp_*` ← `sh_*` if `pending`, and `pending` ← 0.
- Load:
  - `load` writes `sh_*` and sets `pending`.
  - Multiple loads in one frame: the last one wins.
- Load in the boundary cycle: `disp_*` take the incoming `data`/`dp` directly; `pending` stays 0.
- Segment output, evaluated in priority order:
  - `cnt < BLANK`, or `digit_en[num]==0` → `seg = 8'hFF`, `blank = 1`.
  - Otherwise: `seg[6:0]` is the hex glyph of `disp_data[4num+3:4num]`; `seg[7] = ~disp_dp[num]`; `blank = 0`.
- Glyphs (value→`seg` with dp off):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8;
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - dp on clears bit7.
- `frame` is high in the cycle where `num==0 && cnt==0`, except the first cycle after reset.

## Timing
- All outputs are registered.
- `num`, `seg`, `blank` and `frame` always describe the same slot: they change on the same edge, with no cycle of skew between index and pattern.
- Reset values:
  - `cnt=0`, `num=0`;
  - display and shadow registers 0;
  - `pending=0`, `seg=8'hFF`, `blank=1`, `frame=0`.
- Reset mid-operation aborts the frame and restarts from slot 0 with cleared display.
- A load issued in any non-boundary cycle becomes visible in the first frame starting after it.
  - Worst-case latency is 8·DIV cycles.
- `digit_en` changes take effect on the next edge.
- `load` is ignored while `rst` is high.

## Test plan
All scenarios run with DIV=8, BLANK=2.
- Reset/scan: hold `rst` 3 cycles → `num=0`, `seg=FF`, `blank=1`, `frame=0`, `pending=0`. After release, `num` steps 0,1,…,7,0 every 8 cycles. `frame` pulses once per 64 cycles, starting with the second frame.
- Frame-aligned load: `digit_en=FF`, `dp=0`; load `32'h76543210` at cycle 20 → `pending=1` and the display keeps showing `C0` on all digits until the wrap. The next frame shows unblanked digits 0..7 = C0,F9,A4,B0,99,92,82,F8, and `pending=0`.
- Blanking/enable: in every slot, cycles 0–1 give `seg=FF`, `blank=1`; cycles 2–7 give the glyph. With `digit_en=8'b11111011`, slot 2 is `FF`/`blank=1` for all 8 cycles and other slots are unchanged.
- Decimal point and hex: load `32'hFEDCBA98` with `dp=8'h81` → digit 0 = `00`, digit 1 = `90`, digit 7 = `0E`.
- Boundary and double load:
  - Load `A` at `num=3`, then `B` at `num=5` → next frame shows `B`.
  - A load coinciding with the boundary cycle shows its data in the immediately following frame, with `pending` never set.
- Reset mid-frame: assert `rst` at `num=4` → next cycle `num=0`, `seg=FF`, display cleared to zeros, shadow discarded.
